// File: rtl/div_int_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, fixed WIDTH+2 cycle issue period.
// Results are held in Q/R/div_by_zero until the next operation completes.
module div_int_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   step;

    // Returns {quotient bit, next remainder}; the extra top bit of the subtraction is the borrow.
    function automatic logic [WIDTH:0] div_step(
        input logic [WIDTH-1:0] rem_in,
        input logic             dvd_msb,
        input logic [WIDTH-1:0] dvs_in
    );
        logic [WIDTH:0]   partial;
        logic [WIDTH+1:0] trial;
        partial = {rem_in, dvd_msb};
        trial   = {1'b0, partial} - {2'b00, dvs_in};
        if (trial[WIDTH+1]) begin
            return {1'b0, partial[WIDTH-1:0]};
        end
        return {1'b1, trial[WIDTH-1:0]};
    endfunction

    assign step = div_step(rem, dvd[WIDTH-1], dvs);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    state_next = S_FIN;
                end
            end
            S_FIN: begin
                busy       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            quo         <= '0;
            cnt         <= '0;
            done        <= 1'b0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dvd <= A;
                        dvs <= B;
                        rem <= '0;
                        quo <= '0;
                        cnt <= '0;
                    end
                end
                S_RUN: begin
                    rem <= step[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], step[WIDTH]};
                    dvd <= dvd << 1;
                    cnt <= cnt + CW'(1);
                end
                S_FIN: begin
                    Q           <= quo;
                    R           <= rem;
                    div_by_zero <= (dvs == '0);
                    done        <= 1'b1;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_int_seq.sv
// Bench for div_int_seq: directed table at WIDTH=8, multi-cycle corner sequences, and random
// operations at WIDTH=2/8/16 checked against plain integer division.
module tb_div_int_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       st2, bs2, dn2, dz2;
    logic [1:0] a2, b2, q2, r2;
    logic       st8, bs8, dn8, dz8;
    logic [7:0] a8, b8, q8, r8;
    logic        st16, bs16, dn16, dz16;
    logic [15:0] a16, b16, q16, r16;

    div_int_seq #(.WIDTH(2)) u2 (
        .clk(clk), .rst(rst), .start(st2), .A(a2), .B(b2),
        .busy(bs2), .done(dn2), .Q(q2), .R(r2), .div_by_zero(dz2)
    );
    div_int_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(st8), .A(a8), .B(b8),
        .busy(bs8), .done(dn8), .Q(q8), .R(r8), .div_by_zero(dz8)
    );
    div_int_seq #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(st16), .A(a16), .B(b16),
        .busy(bs16), .done(dn16), .Q(q16), .R(r16), .div_by_zero(dz16)
    );

    int total = 0;
    int bad = 0;
    logic [15:0] prev_q [0:16];
    logic [15:0] prev_r [0:16];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic logic get_busy(input int w);
        case (w)
            2:       return bs2;
            8:       return bs8;
            default: return bs16;
        endcase
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            2:       return dn2;
            8:       return dn8;
            default: return dn16;
        endcase
    endfunction

    function automatic logic get_dz(input int w);
        case (w)
            2:       return dz2;
            8:       return dz8;
            default: return dz16;
        endcase
    endfunction

    function automatic logic [15:0] get_q(input int w);
        case (w)
            2:       return 16'(q2);
            8:       return 16'(q8);
            default: return q16;
        endcase
    endfunction

    function automatic logic [15:0] get_r(input int w);
        case (w)
            2:       return 16'(r2);
            8:       return 16'(r8);
            default: return r16;
        endcase
    endfunction

    task automatic set_in(input int w, input logic s, input logic [15:0] a, input logic [15:0] b);
        case (w)
            2:       begin st2 = s;  a2 = a[1:0];  b2 = b[1:0];  end
            8:       begin st8 = s;  a8 = a[7:0];  b8 = b[7:0];  end
            default: begin st16 = s; a16 = a;      b16 = b;      end
        endcase
    endtask

    task automatic clear_prev();
        for (int i = 0; i <= 16; i++) begin
            prev_q[i] = '0;
            prev_r[i] = '0;
        end
    endtask

    // One complete operation: accept, garbage on the inputs while busy, wait for done, check everything.
    task automatic run_op(input int w, input logic [15:0] a_in, input logic [15:0] b_in,
                          output logic [15:0] gq, output logic [15:0] gr, output logic gdz);
        logic [15:0] mask, a, b, eq, er;
        logic        edz;
        int          nb, n, hold_bad;
        mask = (w == 16) ? 16'hFFFF : ((16'd1 << w) - 16'd1);
        a = a_in & mask;
        b = b_in & mask;
        if (b == 0) begin
            eq = mask; er = a; edz = 1'b1;
        end else begin
            eq = a / b; er = a % b; edz = 1'b0;
        end
        @(negedge clk);
        set_in(w, 1'b1, a, b);
        @(posedge clk); #1;
        set_in(w, 1'b0, ~a, ~b);
        nb = 0; n = 0; hold_bad = 0;
        while (!get_done(w) && n < 60) begin
            if (get_busy(w)) nb++;
            if (get_q(w) !== prev_q[w] || get_r(w) !== prev_r[w]) hold_bad++;
            @(posedge clk); #1;
            n++;
        end
        gq = get_q(w); gr = get_r(w); gdz = get_dz(w);
        if (n >= 60) begin
            chk("done_timeout", 64'(n), 64'(w + 1));
            return;
        end
        chk("latency", 64'(n), 64'(w + 1));
        chk("busy_cycles", 64'(nb), 64'(w + 1));
        chk("held_while_busy", 64'(hold_bad), 64'd0);
        chk("quotient", 64'(gq), 64'(eq));
        chk("remainder", 64'(gr), 64'(er));
        chk("div_by_zero", 64'(gdz), 64'(edz));
        if (b != 0) begin
            chk("identity", 64'(gq) * 64'(b) + 64'(gr), 64'(a));
            chk("rem_lt_div", 64'(gr < b), 64'd1);
        end
        prev_q[w] = eq;
        prev_r[w] = er;
        @(posedge clk); #1;
        chk("done_pulse_width", 64'(get_done(w)), 64'd0);
    endtask

    initial begin
        logic [15:0] gq, gr, ra, rb;
        logic        gdz;
        int          ndone, last, nd;

        tbl[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
        tbl[1] = '{8'hFF,  8'h01,  8'hFF,  8'd0,   1'b0};
        tbl[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
        tbl[3] = '{8'd37,  8'd0,   8'hFF,  8'd37,  1'b1};
        tbl[4] = '{8'd9,   8'd3,   8'd3,   8'd0,   1'b0};
        tbl[5] = '{8'd200, 8'd10,  8'd20,  8'd0,   1'b0};
        tbl[6] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
        tbl[7] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
        tbl[8] = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0};
        tbl[9] = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1};

        rst = 1'b1;
        set_in(2, 1'b0, '0, '0);
        set_in(8, 1'b0, '0, '0);
        set_in(16, 1'b0, '0, '0);
        clear_prev();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(bs8), 64'd0);
        chk("reset_done", 64'(dn8), 64'd0);
        chk("reset_q", 64'(q8), 64'd0);
        chk("reset_r", 64'(r8), 64'd0);
        chk("reset_dz", 64'(dz8), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(8, 16'(tbl[i].a), 16'(tbl[i].b), gq, gr, gdz);
            chk("tbl_q", 64'(gq), 64'(tbl[i].q));
            chk("tbl_r", 64'(gr), 64'(tbl[i].r));
            chk("tbl_dz", 64'(gdz), 64'(tbl[i].dz));
        end

        // Divide-by-zero flag is held through idle and cleared by the next valid op.
        run_op(8, 16'd37, 16'd0, gq, gr, gdz);
        repeat (3) @(posedge clk);
        #1;
        chk("dz_hold_flag", 64'(dz8), 64'd1);
        chk("dz_hold_q", 64'(q8), 64'hFF);
        chk("dz_hold_r", 64'(r8), 64'd37);
        run_op(8, 16'd9, 16'd3, gq, gr, gdz);
        chk("dz_cleared", 64'(gdz), 64'd0);

        // start held high: one accept per done cycle, operands disturbed while busy.
        ndone = 0; last = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            st8 = 1'b1;
            if (!bs8) begin
                a8 = 8'd200; b8 = 8'd10;
            end else begin
                a8 = 8'($urandom); b8 = 8'($urandom);
            end
            @(posedge clk); #1;
            if (dn8) begin
                ndone++;
                chk("held_start_q", 64'(q8), 64'd20);
                chk("held_start_r", 64'(r8), 64'd0);
                if (last >= 0) chk("held_start_period", 64'(i - last), 64'd10);
                last = i;
            end
        end
        @(negedge clk);
        st8 = 1'b0;
        chk("held_start_count", 64'(ndone), 64'd3);
        prev_q[8] = 16'd20;
        prev_r[8] = 16'd0;
        repeat (12) @(posedge clk);

        // Reset four cycles into RUN aborts with no done.
        run_op(8, 16'd100, 16'd7, gq, gr, gdz);
        @(negedge clk);
        set_in(8, 1'b1, 16'd50, 16'd3);
        @(posedge clk); #1;
        set_in(8, 1'b0, 16'd50, 16'd3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 64'(bs8), 64'd0);
        chk("abort_done", 64'(dn8), 64'd0);
        chk("abort_q", 64'(q8), 64'd0);
        chk("abort_r", 64'(r8), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_prev();
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (dn8) nd++;
        end
        chk("abort_no_done", 64'(nd), 64'd0);
        run_op(8, 16'd50, 16'd3, gq, gr, gdz);
        chk("after_abort_q", 64'(gq), 64'd16);

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            run_op(2, ra, rb, gq, gr, gdz);
        end
        for (int i = 0; i < 2000; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom);
            run_op(8, ra, rb, gq, gr, gdz);
        end
        for (int i = 0; i < 1500; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 16'd0;
                1:       rb = 16'($urandom_range(1, 255));
                default: rb = 16'($urandom);
            endcase
            run_op(16, ra, rb, gq, gr, gdz);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
